// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC1 microsequencer: control-word layout,
// sequencer states, B-bus select codes and the idle MIR pattern.
package mic1_pkg;

  localparam int CW_W     = 36;
  localparam int MPC_W    = 9;
  localparam int MIR_W    = 16;
  localparam int ALU_W    = 8;

  localparam int NA_HI    = 35;
  localparam int NA_LO    = 27;
  localparam int JMPC_BIT = 26;
  localparam int JAMN_BIT = 25;
  localparam int JAMZ_BIT = 24;
  localparam int ALU_HI   = 23;
  localparam int ALU_LO   = 16;
  localparam int C_HI     = 15;
  localparam int C_LO     = 7;
  localparam int WR_BIT   = 6;
  localparam int RD_BIT   = 5;
  localparam int FE_BIT   = 4;
  localparam int B_HI     = 3;
  localparam int B_LO     = 0;

  localparam logic [MIR_W-1:0] MIR_IDLE = 16'h000F;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    B_MDR  = 4'h0,
    B_PC   = 4'h1,
    B_MBR  = 4'h2,
    B_MBRU = 4'h3,
    B_SP   = 4'h4,
    B_LV   = 4'h5,
    B_CPP  = 4'h6,
    B_TOS  = 4'h7,
    B_OPC  = 4'h8,
    B_NONE = 4'hF
  } b_sel_e;

  // Memory request field {write, read, fetch} of a control word.
  function automatic logic [2:0] cw_mem(input logic [CW_W-1:0] cw);
    return cw[WR_BIT:FE_BIT];
  endfunction

endpackage

// File: rtl/mic1_next_addr.sv
// Combinational next-MPC: NEXT_ADDRESS with JAMN/JAMZ ORed into bit 8 and
// MBR ORed into the low byte for JMPC. No carries; contributions just OR.
module mic1_next_addr
  import mic1_pkg::*;
(
  input  logic [MPC_W-1:0] i_next_addr,
  input  logic             i_jmpc,
  input  logic             i_jamn,
  input  logic             i_jamz,
  input  logic             i_n,
  input  logic             i_z,
  input  logic [7:0]       i_mbr,
  output logic [MPC_W-1:0] o_mpc
);

  logic       w_hi_bit;
  logic [7:0] w_lo_byte;

  // OR-combine the branch contributions onto the base address.
  always_comb begin
    w_hi_bit  = i_next_addr[8] | (i_jamn & i_n) | (i_jamz & i_z);
    w_lo_byte = i_next_addr[7:0] | (i_jmpc ? i_mbr : 8'h00);
    o_mpc     = {w_hi_bit, w_lo_byte};
  end

endmodule

// File: rtl/mic1_microsequencer.sv
// MIC1 control unit: fetch/execute/wait sequencing over a synchronous control
// store, memory handshakes with timeout, and next-MPC selection.
module mic1_microsequencer
  import mic1_pkg::*;
#(
  parameter logic [8:0] HALT_ADDR   = 9'h1FF,
  parameter int         MEM_TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  output logic [MPC_W-1:0]    cs_addr,
  input  logic [CW_W-1:0]     cs_data,
  input  logic                alu_n,
  input  logic                alu_z,
  input  logic [7:0]          mbr_byte,
  output logic [MIR_W-1:0]    mir_out,
  output logic [ALU_W-1:0]    alu_ctrl,
  output logic                ram_rd,
  output logic                ram_wr,
  input  logic                ram_ready,
  output logic                rom_fetch,
  input  logic                rom_ready,
  output logic                halted,
  output logic                mem_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  state_e            r_state;
  logic [MPC_W-1:0]  r_mpc;
  logic [CW_W-1:0]   r_mir;
  logic              r_n;
  logic              r_z;
  logic [2:0]        r_pend;       // {wr, rd, fetch}
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_mem_err;

  state_e            w_state_nx;
  logic [MPC_W-1:0]  w_mpc_nx;
  logic [CW_W-1:0]   w_mir_nx;
  logic              w_n_nx;
  logic              w_z_nx;
  logic [2:0]        w_pend_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              w_err_nx;

  logic [2:0]        w_mem;
  logic [2:0]        w_done;
  logic [2:0]        w_left;
  logic              w_n_sel;
  logic              w_z_sel;
  logic [MPC_W-1:0]  w_next_mpc;

  // Flags come straight from the ALU when leaving EXEC, else from the latch.
  always_comb begin
    w_mem   = cw_mem(r_mir);
    w_done  = r_pend & {ram_ready, ram_ready, rom_ready};
    w_left  = r_pend & ~w_done;
    w_n_sel = (r_state == ST_EXEC) ? alu_n : r_n;
    w_z_sel = (r_state == ST_EXEC) ? alu_z : r_z;
  end

  mic1_next_addr u_next_addr (
    .i_next_addr (r_mir[NA_HI:NA_LO]),
    .i_jmpc      (r_mir[JMPC_BIT]),
    .i_jamn      (r_mir[JAMN_BIT]),
    .i_jamz      (r_mir[JAMZ_BIT]),
    .i_n         (w_n_sel),
    .i_z         (w_z_sel),
    .i_mbr       (mbr_byte),
    .o_mpc       (w_next_mpc)
  );

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_mpc_nx   = r_mpc;
    w_mir_nx   = r_mir;
    w_n_nx     = r_n;
    w_z_nx     = r_z;
    w_pend_nx  = r_pend;
    w_cnt_nx   = r_wait_cnt;
    w_err_nx   = r_mem_err;
    case (r_state)
      ST_FETCH: begin
        if (r_mpc == HALT_ADDR) begin
          w_state_nx = ST_HALT;
        end else begin
          w_mir_nx   = cs_data;
          w_state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_n_nx = alu_n;
        w_z_nx = alu_z;
        if (w_mem == 3'b000) begin
          w_mpc_nx   = w_next_mpc;
          w_state_nx = ST_FETCH;
        end else begin
          // A write suppresses a read issued in the same microinstruction.
          w_pend_nx  = {w_mem[2], w_mem[1] & ~w_mem[2], w_mem[0]};
          w_cnt_nx   = '0;
          w_state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // One drain cycle after the last completion lets MBR settle for JMPC.
        if (r_pend == 3'b000) begin
          w_mpc_nx   = w_next_mpc;
          w_state_nx = ST_FETCH;
        end else if ((w_left != 3'b000) && (MEM_TIMEOUT != 0) &&
                     (r_wait_cnt == CNT_LIMIT)) begin
          w_err_nx   = 1'b1;
          w_pend_nx  = 3'b000;
          w_state_nx = ST_HALT;
        end else begin
          w_pend_nx  = w_left;
          w_cnt_nx   = r_wait_cnt + CNT_W'(1);
        end
      end
      ST_HALT: begin
        w_state_nx = ST_HALT;
      end
      default: begin
        w_state_nx = ST_FETCH;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_mpc      <= '0;
      r_mir      <= '0;
      r_n        <= 1'b0;
      r_z        <= 1'b0;
      r_pend     <= 3'b000;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_mpc      <= w_mpc_nx;
      r_mir      <= w_mir_nx;
      r_n        <= w_n_nx;
      r_z        <= w_z_nx;
      r_pend     <= w_pend_nx;
      r_wait_cnt <= w_cnt_nx;
      r_mem_err  <= w_err_nx;
    end
  end

  // Datapath MIR and ALU control decode; load pulses track the ready inputs.
  always_comb begin
    mir_out  = MIR_IDLE;
    alu_ctrl = 8'h00;
    case (r_state)
      ST_EXEC: begin
        mir_out  = {r_mir[C_HI:C_LO], 3'b000, r_mir[B_HI:B_LO]};
        alu_ctrl = r_mir[ALU_HI:ALU_LO];
      end
      ST_WAIT: begin
        mir_out = {9'h000, 1'b0, w_done[1], w_done[0], B_NONE};
      end
      default: begin
        mir_out  = MIR_IDLE;
        alu_ctrl = 8'h00;
      end
    endcase
  end

  assign cs_addr   = r_mpc;
  assign ram_wr    = r_pend[2];
  assign ram_rd    = r_pend[1];
  assign rom_fetch = r_pend[0];
  assign halted    = (r_state == ST_HALT);
  assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_mic1_microsequencer.sv
// Directed bench for mic1_microsequencer; next-address expectations go
// through a scoreboard queue and are checked when the following FETCH appears.
module tb_mic1_microsequencer;

  logic        clock;
  logic        reset;
  logic [8:0]  cs_addr;
  logic [35:0] cs_data;
  logic        alu_n;
  logic        alu_z;
  logic [7:0]  mbr_byte;
  logic [15:0] mir_out;
  logic [7:0]  alu_ctrl;
  logic        ram_rd;
  logic        ram_wr;
  logic        ram_ready;
  logic        rom_fetch;
  logic        rom_ready;
  logic        halted;
  logic        mem_err;

  logic [35:0] rom [512];
  logic [8:0]  exp_q [$];
  int          n_chk;
  int          n_pass;

  assign cs_data = rom[cs_addr];

  mic1_microsequencer #(.HALT_ADDR(9'h1FF), .MEM_TIMEOUT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cs_addr   (cs_addr),
    .cs_data   (cs_data),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .mbr_byte  (mbr_byte),
    .mir_out   (mir_out),
    .alu_ctrl  (alu_ctrl),
    .ram_rd    (ram_rd),
    .ram_wr    (ram_wr),
    .ram_ready (ram_ready),
    .rom_fetch (rom_fetch),
    .rom_ready (rom_ready),
    .halted    (halted),
    .mem_err   (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [35:0] mk(input logic [8:0] na, input logic [2:0] jam,
                                     input logic [7:0] alu, input logic [8:0] c,
                                     input logic [2:0] mem, input logic [3:0] b);
    return {na, jam, alu, c, mem, b};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_fetch(input string tag);
    logic [8:0] e;
    e = 9'bx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, {27'd0, cs_addr}, {27'd0, e});
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    alu_n = 1'b0; alu_z = 1'b0; mbr_byte = 8'h00;
    ram_ready = 1'b0; rom_ready = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = 36'd0;
    rom[0]      = mk(9'h001, 3'b000, 8'h3C, 9'h100, 3'b000, 4'h5);
    rom[1]      = mk(9'h092, 3'b001, 8'h00, 9'h000, 3'b000, 4'h0);
    rom[9'h192] = mk(9'h003, 3'b000, 8'h14, 9'h002, 3'b000, 4'h7);
    rom[3]      = mk(9'h092, 3'b001, 8'h00, 9'h000, 3'b000, 4'h0);
    rom[9'h092] = mk(9'h010, 3'b010, 8'h00, 9'h000, 3'b000, 4'h0);
    rom[9'h110] = mk(9'h000, 3'b100, 8'h00, 9'h000, 3'b001, 4'h2);
    rom[9'h060] = mk(9'h061, 3'b000, 8'h35, 9'h1FF, 3'b010, 4'h0);
    rom[9'h061] = mk(9'h062, 3'b000, 8'h00, 9'h000, 3'b011, 4'h1);
    rom[9'h062] = mk(9'h063, 3'b000, 8'h00, 9'h000, 3'b110, 4'h3);
    rom[9'h063] = mk(9'h1FF, 3'b000, 8'h00, 9'h000, 3'b000, 4'hF);

    reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    chk("rst_cs_addr", {27'd0, cs_addr}, 36'd0);
    chk("rst_mir", {20'd0, mir_out}, 36'h000F);
    chk("rst_alu", {28'd0, alu_ctrl}, 36'd0);
    chk("rst_req", {33'd0, ram_rd, ram_wr, rom_fetch}, 36'd0);
    chk("rst_flags", {34'd0, halted, mem_err}, 36'd0);
    reset = 1'b0;
    #1;
    chk("fetch0_addr", {27'd0, cs_addr}, 36'd0);
    chk("fetch0_mir", {20'd0, mir_out}, 36'h000F);

    tick();  // EXEC @0: C=H
    chk("exec0_mir", {20'd0, mir_out}, 36'h8005);
    chk("exec0_alu", {28'd0, alu_ctrl}, 36'h3C);
    exp_q.push_back(9'h001);
    tick();
    chk_fetch("next_0");
    chk("fetch1_mir", {20'd0, mir_out}, 36'h000F);

    tick();  // EXEC @1: JAMZ with Z=1
    alu_z = 1'b1;
    exp_q.push_back(9'h192);
    tick();
    alu_z = 1'b0;
    chk_fetch("jamz_taken");

    tick();  // EXEC @192
    chk("exec192_mir", {20'd0, mir_out}, 36'h0107);
    chk("exec192_alu", {28'd0, alu_ctrl}, 36'h14);
    exp_q.push_back(9'h003);
    tick();
    chk_fetch("next_192");

    tick();  // EXEC @3: JAMZ with Z=0
    exp_q.push_back(9'h092);
    tick();
    chk_fetch("jamz_not_taken");

    tick();  // EXEC @92: JAMN with N=1
    alu_n = 1'b1;
    exp_q.push_back(9'h110);
    tick();
    alu_n = 1'b0;
    chk_fetch("jamn_taken");

    mbr_byte = 8'h0F;
    tick();  // EXEC @110: JMPC + fetch
    chk("exec110_mir", {20'd0, mir_out}, 36'h0002);
    exp_q.push_back(9'h060);
    tick();  // WAIT1
    chk("jmpc_w1_fetch", {35'd0, rom_fetch}, 36'd1);
    chk("jmpc_w1_mir", {20'd0, mir_out}, 36'h000F);
    tick();  // WAIT2
    chk("jmpc_w2_fetch", {35'd0, rom_fetch}, 36'd1);
    tick();  // WAIT3: ROM done
    rom_ready = 1'b1;
    #1;
    chk("jmpc_mbr_pulse", {20'd0, mir_out}, 36'h001F);
    tick();  // drain
    rom_ready = 1'b0;
    mbr_byte = 8'h60;
    #1;
    chk("jmpc_drain_fetch", {35'd0, rom_fetch}, 36'd0);
    chk("jmpc_drain_mir", {20'd0, mir_out}, 36'h000F);
    tick();
    chk_fetch("jmpc_addr");
    mbr_byte = 8'h00;

    tick();  // EXEC @60: read
    chk("exec60_mir", {20'd0, mir_out}, 36'hFF80);
    chk("exec60_alu", {28'd0, alu_ctrl}, 36'h35);
    exp_q.push_back(9'h061);
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk($sformatf("rd_w%0d_req", k), {35'd0, ram_rd}, 36'd1);
      chk($sformatf("rd_w%0d_mir", k), {20'd0, mir_out}, 36'h000F);
    end
    tick();
    ram_ready = 1'b1;
    #1;
    chk("rd_w3_req", {35'd0, ram_rd}, 36'd1);
    chk("rd_w3_mdr_pulse", {20'd0, mir_out}, 36'h002F);
    tick();
    ram_ready = 1'b0;
    #1;
    chk("rd_drain", {19'd0, ram_rd, mir_out}, 36'h000F);
    tick();
    chk_fetch("rd_next");

    tick();  // EXEC @61: read + fetch
    exp_q.push_back(9'h062);
    tick();
    rom_ready = 1'b1;
    #1;
    chk("rf_w1_pulse", {20'd0, mir_out}, 36'h001F);
    chk("rf_w1_req", {34'd0, ram_rd, rom_fetch}, 36'd3);
    tick();
    rom_ready = 1'b0;
    ram_ready = 1'b1;
    #1;
    chk("rf_w2_pulse", {20'd0, mir_out}, 36'h002F);
    chk("rf_w2_req", {34'd0, ram_rd, rom_fetch}, 36'd2);
    tick();
    ram_ready = 1'b0;
    #1;
    chk("rf_drain", {18'd0, ram_rd, rom_fetch, mir_out}, 36'h000F);
    tick();
    chk_fetch("rf_next");

    tick();  // EXEC @62: write + read
    exp_q.push_back(9'h063);
    tick();
    chk("wr_req", {34'd0, ram_wr, ram_rd}, 36'd2);
    ram_ready = 1'b1;
    #1;
    chk("wr_no_mdr", {20'd0, mir_out}, 36'h000F);
    tick();
    ram_ready = 1'b0;
    #1;
    chk("wr_drain", {35'd0, ram_wr}, 36'd0);
    tick();
    chk_fetch("wr_next");

    tick();  // EXEC @63 -> HALT_ADDR
    exp_q.push_back(9'h1FF);
    tick();
    chk_fetch("halt_addr");
    chk("pre_halt", {35'd0, halted}, 36'd0);
    tick();
    chk("halted", {20'd0, mir_out}, 36'h000F);
    chk("halted_flag", {34'd0, halted, mem_err}, 36'd2);
    tick();
    tick();
    chk("halted_stays", {35'd0, halted}, 36'd1);

    // Timeout: read that never completes.
    rom[0] = mk(9'h005, 3'b000, 8'h00, 9'h000, 3'b010, 4'h0);
    reset = 1'b1;
    #1;
    chk("rst2_halted", {35'd0, halted}, 36'd0);
    tick();
    reset = 1'b0;
    tick();  // EXEC
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("to_w%0d", k), {33'd0, ram_rd, mem_err, halted}, 36'd4);
    end
    tick();
    chk("to_err", {33'd0, ram_rd, mem_err, halted}, 36'd3);
    tick();
    chk("to_sticky", {35'd0, mem_err}, 36'd1);

    // Reset in the middle of a WAIT drops the request at once.
    reset = 1'b1;
    #1;
    chk("rst3_err_clr", {34'd0, mem_err, halted}, 36'd0);
    tick();
    reset = 1'b0;
    tick();  // EXEC
    tick();  // WAIT1
    chk("mid_wait_rd", {35'd0, ram_rd}, 36'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_drop_rd", {35'd0, ram_rd}, 36'd0);
    chk("async_addr", {27'd0, cs_addr}, 36'd0);
    tick();
    reset = 1'b0;

    chk("queue_empty", 36'(exp_q.size()), 36'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
